cache_way_array: RTL and testbench

Parametrised multi-way storage bank for the L1 caches. It bundles tag, valid and data RAMs for `WAYS` ways into one block, with a registered lookup and per-way hit vector. It clears all valid bits with a sequential sweep after reset or on request, because BRAM contents cannot be reset. Write-to-read collisions are bypassed in write-first order. It replaces the separate per-field RAM wrappers and sits between the cache controller FSM and the `DualPortBram` primitives.

---
 rtl/cache_way_array.sv | 164 ++++++++++++++++
 tb/tb_cache_way_array.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_way_array.sv
// Multi-way tag/valid/data storage bank with registered lookup, per-way hit vector,
// write-first collision bypass and a sequential valid-clear sweep after reset or on request.
module cache_way_array #(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned SETS     = 128,
    parameter int unsigned TAG_WID  = 20,
    parameter int unsigned DATA_WID = 32,
    parameter int unsigned IDX_WID  = $clog2(SETS),
    parameter int unsigned BE_WID   = DATA_WID / 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rd_en,
    input  logic [IDX_WID-1:0]       rd_idx,
    input  logic [TAG_WID-1:0]       rd_cmp_tag,
    output logic [WAYS*TAG_WID-1:0]  rd_tag,
    output logic [WAYS-1:0]          rd_valid,
    output logic [WAYS*DATA_WID-1:0] rd_data,
    output logic [WAYS-1:0]          rd_hit,
    input  logic                     wr_en,
    input  logic [WAYS-1:0]          wr_way,
    input  logic [IDX_WID-1:0]       wr_idx,
    input  logic                     wr_tag_en,
    input  logic [TAG_WID-1:0]       wr_tag,
    input  logic                     wr_valid,
    input  logic [BE_WID-1:0]        wr_be,
    input  logic [DATA_WID-1:0]      wr_data,
    input  logic                     inv_all,
    output logic                     busy
);

    localparam logic [IDX_WID-1:0] LAST_SET = IDX_WID'(SETS - 1);

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WID-1:0]   cnt_q, cnt_d;
    logic                 busy_d;
    logic                 sweep_we;
    logic                 rd_act;
    logic                 wr_act;
    logic                 clr_out;

    logic [TAG_WID-1:0]   tag_mem   [WAYS][SETS];
    logic                 valid_mem [WAYS][SETS];
    logic [DATA_WID-1:0]  data_mem  [WAYS][SETS];

    logic [WAYS*TAG_WID-1:0]  byp_tag;
    logic [WAYS-1:0]          byp_valid;
    logic [WAYS*DATA_WID-1:0] byp_data;
    logic [WAYS-1:0]          byp_hit;
    logic                     same_idx;

    // State, sweep counter and busy flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
        end
    end

    // Next state; the sweep ends on the last index, not on counter overflow
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        rd_act   = 1'b0;
        wr_act   = 1'b0;
        clr_out  = 1'b0;
        case (state_q)
            SWEEP: begin
                sweep_we = 1'b1;
                clr_out  = 1'b1;
                cnt_d    = cnt_q + IDX_WID'(1);
                if (cnt_q == LAST_SET) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (inv_all) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    clr_out = 1'b1;
                end else begin
                    rd_act = rd_en & rstn;
                    wr_act = wr_en & rstn;
                end
            end
            default: state_d = SWEEP;
        endcase
        busy_d = (state_d == SWEEP);
    end

    // Storage arrays; only valid bits are touched by the sweep
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (sweep_we) begin
                valid_mem[w][cnt_q] <= 1'b0;
            end else if (wr_act && wr_way[w] && wr_tag_en) begin
                tag_mem[w][wr_idx]   <= wr_tag;
                valid_mem[w][wr_idx] <= wr_valid;
            end
            if (wr_act && wr_way[w]) begin
                for (int b = 0; b < BE_WID; b++) begin
                    if (wr_be[b]) begin
                        data_mem[w][wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign same_idx = (wr_idx == rd_idx);

    // Read path with write-first merge of a same-cycle write to the same set
    always_comb begin
        byp_tag   = '0;
        byp_valid = '0;
        byp_data  = '0;
        byp_hit   = '0;
        for (int w = 0; w < WAYS; w++) begin
            byp_tag[w*TAG_WID +: TAG_WID]    = tag_mem[w][rd_idx];
            byp_valid[w]                     = valid_mem[w][rd_idx];
            byp_data[w*DATA_WID +: DATA_WID] = data_mem[w][rd_idx];
            if (wr_act && wr_way[w] && same_idx) begin
                for (int b = 0; b < BE_WID; b++) begin
                    if (wr_be[b]) begin
                        byp_data[w*DATA_WID + b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
                if (wr_tag_en) begin
                    byp_tag[w*TAG_WID +: TAG_WID] = wr_tag;
                    byp_valid[w]                  = wr_valid;
                end
            end
            byp_hit[w] = byp_valid[w] && (byp_tag[w*TAG_WID +: TAG_WID] == rd_cmp_tag);
        end
    end

    // Output registers: cleared while sweeping, held when no lookup
    always_ff @(posedge clk) begin
        if (!rstn || clr_out) begin
            rd_tag   <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            rd_hit   <= '0;
        end else if (rd_act) begin
            rd_tag   <= byp_tag;
            rd_valid <= byp_valid;
            rd_data  <= byp_data;
            rd_hit   <= byp_hit;
        end
    end

endmodule

// File: tb/tb_cache_way_array.sv
// Bench for cache_way_array: directed scenarios plus randomized traffic against an
// array-based reference model that applies writes before reads.
module tb_cache_way_array;

    localparam int unsigned WAYS     = 2;
    localparam int unsigned SETS     = 128;
    localparam int unsigned TAG_WID  = 20;
    localparam int unsigned DATA_WID = 32;
    localparam int unsigned IDX_WID  = 7;
    localparam int unsigned BE_WID   = 4;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     rd_en;
    logic [IDX_WID-1:0]       rd_idx;
    logic [TAG_WID-1:0]       rd_cmp_tag;
    logic [WAYS*TAG_WID-1:0]  rd_tag;
    logic [WAYS-1:0]          rd_valid;
    logic [WAYS*DATA_WID-1:0] rd_data;
    logic [WAYS-1:0]          rd_hit;
    logic                     wr_en;
    logic [WAYS-1:0]          wr_way;
    logic [IDX_WID-1:0]       wr_idx;
    logic                     wr_tag_en;
    logic [TAG_WID-1:0]       wr_tag;
    logic                     wr_valid;
    logic [BE_WID-1:0]        wr_be;
    logic [DATA_WID-1:0]      wr_data;
    logic                     inv_all;
    logic                     busy;

    always #5 clk = ~clk;

    cache_way_array #(
        .WAYS(WAYS), .SETS(SETS), .TAG_WID(TAG_WID), .DATA_WID(DATA_WID),
        .IDX_WID(IDX_WID), .BE_WID(BE_WID)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_cmp_tag(rd_cmp_tag),
        .rd_tag(rd_tag), .rd_valid(rd_valid), .rd_data(rd_data), .rd_hit(rd_hit),
        .wr_en(wr_en), .wr_way(wr_way), .wr_idx(wr_idx), .wr_tag_en(wr_tag_en),
        .wr_tag(wr_tag), .wr_valid(wr_valid), .wr_be(wr_be), .wr_data(wr_data),
        .inv_all(inv_all), .busy(busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [TAG_WID-1:0]       m_tag   [WAYS][SETS];
    logic                     m_valid [WAYS][SETS];
    logic [DATA_WID-1:0]      m_data  [WAYS][SETS];
    int                       sweep_left = 0;
    logic                     e_busy;
    logic [WAYS*TAG_WID-1:0]  e_tag;
    logic [WAYS-1:0]          e_valid;
    logic [WAYS*DATA_WID-1:0] e_data;
    logic [WAYS-1:0]          e_hit;
    int                       busy_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void clear_model_outputs();
        e_tag   = '0;
        e_valid = '0;
        e_data  = '0;
        e_hit   = '0;
    endfunction

    function automatic void start_sweep();
        sweep_left = SETS;
        e_busy     = 1'b1;
        clear_model_outputs();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                m_valid[w][s] = 1'b0;
    endfunction

    // Expected effect of the upcoming clock edge given the current inputs
    function automatic void model_edge();
        if (!rstn) begin
            start_sweep();
        end else if (sweep_left > 0) begin
            sweep_left--;
            e_busy = (sweep_left > 0);
            clear_model_outputs();
        end else if (inv_all) begin
            start_sweep();
        end else begin
            e_busy = 1'b0;
            if (wr_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (wr_way[w]) begin
                        for (int b = 0; b < BE_WID; b++)
                            if (wr_be[b]) m_data[w][wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
                        if (wr_tag_en) begin
                            m_tag[w][wr_idx]   = wr_tag;
                            m_valid[w][wr_idx] = wr_valid;
                        end
                    end
                end
            end
            if (rd_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    e_tag[w*TAG_WID +: TAG_WID]    = m_tag[w][rd_idx];
                    e_valid[w]                     = m_valid[w][rd_idx];
                    e_data[w*DATA_WID +: DATA_WID] = m_data[w][rd_idx];
                    e_hit[w] = m_valid[w][rd_idx] && (m_tag[w][rd_idx] == rd_cmp_tag);
                end
            end
        end
    endfunction

    task automatic step(input bit full);
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(e_busy));
        chk("rd_valid", 64'(rd_valid), 64'(e_valid));
        chk("rd_hit", 64'(rd_hit), 64'(e_hit));
        if (full) begin
            chk("rd_tag", 64'(rd_tag), 64'(e_tag));
            chk("rd_data", 64'(rd_data), 64'(e_data));
        end
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0; inv_all = 1'b0; wr_tag_en = 1'b0; wr_be = '0;
    endtask

    task automatic do_write(input logic [WAYS-1:0] way, input int idx, input logic ten,
                            input logic [TAG_WID-1:0] tag, input logic vld,
                            input logic [BE_WID-1:0] be, input logic [DATA_WID-1:0] data);
        wr_en = 1'b1; wr_way = way; wr_idx = IDX_WID'(idx); wr_tag_en = ten;
        wr_tag = tag; wr_valid = vld; wr_be = be; wr_data = data;
    endtask

    task automatic do_read(input int idx, input logic [TAG_WID-1:0] cmp);
        rd_en = 1'b1; rd_idx = IDX_WID'(idx); rd_cmp_tag = cmp;
    endtask

    task automatic count_sweep(input string tag);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < SETS + 4; i++) begin
            step(1);
            if (busy) busy_cnt++;
        end
        chk(tag, 64'(busy_cnt), 64'(SETS));
    endtask

    initial begin
        rstn = 1'b0; rd_idx = '0; rd_cmp_tag = '0; wr_way = '0; wr_idx = '0;
        wr_tag = '0; wr_valid = 1'b0; wr_data = '0;
        idle();
        e_busy = 1'b1;
        clear_model_outputs();

        // Reset held three cycles, then the power-up sweep
        for (int i = 0; i < 3; i++) step(1);
        rstn = 1'b1;
        count_sweep("reset_sweep_len");

        // Every set reads back invalid after the sweep
        for (int i = 0; i < SETS; i++) begin
            do_read(i, TAG_WID'($urandom));
            step(0);
        end
        idle();

        // Preload every set so tag and data contents are known to the model
        for (int i = 0; i < SETS; i++) begin
            do_write('1, i, 1'b1, TAG_WID'($urandom), 1'b0, '1, $urandom);
            step(0);
        end
        idle();
        step(0);

        // Basic write then read
        do_write(2'b10, 5, 1'b1, 20'hABCDE, 1'b1, 4'b1111, 32'h12345678);
        step(1);
        idle();
        do_read(5, 20'hABCDE);
        step(1);
        chk("basic_hit", 64'(rd_hit), 64'(2'b10));
        chk("basic_data", 64'(rd_data[63:32]), 64'h12345678);

        // Byte-enable partial write keeps tag and valid
        idle();
        do_write(2'b10, 5, 1'b0, 20'h0, 1'b0, 4'b0010, 32'h0000FF00);
        step(1);
        idle();
        do_read(5, 20'hABCDE);
        step(1);
        chk("be_data", 64'(rd_data[63:32]), 64'h1234FF78);
        chk("be_hit", 64'(rd_hit), 64'(2'b10));

        // Same-cycle read/write collision
        idle();
        do_read(9, 20'h00001);
        do_write(2'b01, 9, 1'b1, 20'h00001, 1'b1, 4'b1111, 32'hDEADBEEF);
        step(1);
        chk("byp_hit0", 64'(rd_hit[0]), 64'(1'b1));
        chk("byp_data0", 64'(rd_data[31:0]), 64'hDEADBEEF);

        // inv_all with a concurrent write that must be dropped
        idle();
        do_write('1, 0, 1'b1, 20'h00042, 1'b1, '1, 32'h0BAD0000);
        step(1);
        do_write('1, 127, 1'b1, 20'h00043, 1'b1, '1, 32'h0BAD007F);
        step(1);
        idle();
        do_write('1, 3, 1'b1, 20'h00044, 1'b1, '1, 32'hCAFEF00D);
        inv_all = 1'b1;
        step(1);
        idle();
        count_sweep("inv_sweep_len");
        do_read(0, 20'h00042);
        step(1);
        chk("inv_valid0", 64'(rd_valid), 64'(0));
        do_read(127, 20'h00043);
        step(1);
        chk("inv_valid127", 64'(rd_valid), 64'(0));
        do_read(3, 20'h00044);
        step(1);
        chk("inv_drop3", 64'(rd_hit), 64'(0));
        idle();

        // Reset partway through a sweep restarts it
        inv_all = 1'b1;
        step(1);
        inv_all = 1'b0;
        for (int i = 0; i < 60; i++) step(1);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        count_sweep("restart_sweep_len");

        // Randomized traffic over a few sets to force collisions and hits
        for (int i = 0; i < 3000; i++) begin
            rd_en      = 1'($urandom_range(0, 1));
            rd_idx     = IDX_WID'($urandom_range(0, 7));
            rd_cmp_tag = TAG_WID'($urandom_range(1, 3));
            wr_en      = 1'($urandom_range(0, 1));
            wr_way     = WAYS'($urandom_range(0, 3));
            wr_idx     = IDX_WID'($urandom_range(0, 7));
            wr_tag_en  = 1'($urandom_range(0, 1));
            wr_tag     = TAG_WID'($urandom_range(1, 3));
            wr_valid   = 1'($urandom_range(0, 1));
            wr_be      = BE_WID'($urandom);
            wr_data    = $urandom;
            inv_all    = ($urandom_range(0, 399) == 0);
            step(1);
        end
        idle();
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
